uart_rx_fifo: RTL and testbench

- Hardware UART receiver for the serial RX pin of the f8 system.
- Receives 8N1 frames on an asynchronous input, buffers complete bytes in a small FIFO, and presents them to the system through a valid/ready read port.
- Reports sticky framing and overrun errors.
- Sits between the board RX pin and the system bus glue. It is the receive counterpart to the firmware-driven TX pin.

---
 rtl/uart_rx_fifo.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Purpose : 8N1 UART receiver with a small byte FIFO and a valid/ready read port.
// Latency : byte is pushed on the stop-bit sample edge; rd_valid rises one edge later.
// Backpressure: rd_ready low holds rd_data/rd_valid; a full FIFO drops new bytes and sets overrun.
//
// Ports:
//   clk, power_on_reset_n   system clock, asynchronous active-low reset
//   rxd                     asynchronous serial input, idle high
//   rd_data/rd_valid/rd_ready  FIFO head and handshake (pop on rd_valid & rd_ready)
//   frame_err, overrun      sticky error flags, cleared by clear_err
//   busy                    receiver is inside a frame (or waiting out a break)
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 312,
    parameter int FIFODEPTH    = 4
) (
    input  logic       clk,
    input  logic       power_on_reset_n,
    input  logic       rxd,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       clear_err,
    output logic       busy
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFODEPTH);

    // START is left after (CLKS_PER_BIT-1)/2 clocks so the sample lands mid-bit.
    localparam logic [TW-1:0] T_HALF = TW'((CLKS_PER_BIT - 1) / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_ONE  = TW'(1);
    localparam logic [AW:0]   P_ONE  = (AW + 1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // ---------------------------------------------------------------
    // Input synchronizer (resets to the idle level)
    // ---------------------------------------------------------------
    logic rx_meta_q;
    logic rxs_q;

    always_ff @(posedge clk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rxs_q     <= rx_meta_q;
        end
    end

    // ---------------------------------------------------------------
    // Receiver FSM
    // ---------------------------------------------------------------
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          push;
    logic          frame_set;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q + T_ONE;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (!rxs_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (timer_q == T_HALF) begin
                    timer_d = '0;
                    if (!rxs_q) begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        // Line went back high before mid-bit: treat as noise.
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (timer_q == T_FULL) begin
                    timer_d   = '0;
                    shift_d   = {rxs_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (timer_q == T_FULL) begin
                    timer_d = '0;
                    if (rxs_q) begin
                        // Back to IDLE on the sample itself so a 1-bit stop
                        // still catches a directly following start edge.
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A held-low line must not be decoded as a stream of 0x00 frames.
                timer_d = '0;
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                timer_d = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // ---------------------------------------------------------------
    // Receive FIFO
    // ---------------------------------------------------------------
    logic [7:0]  mem [FIFODEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  rd_data_q;
    logic        rd_valid_q;
    logic        frame_err_q, overrun_q;
    logic        full;
    logic        pop;
    logic        push_ok;
    logic        ovr_set;
    logic        head_vld_d;

    always_comb begin
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop      = rd_valid_q & rd_ready;
        // A pop on the same edge frees the slot the push needs.
        push_ok  = push & (~full | pop);
        ovr_set  = push & full & ~pop;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + P_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + P_ONE;
        end
        // Compared against the pre-push write pointer: a byte pushed on this
        // edge becomes visible one edge later.
        head_vld_d = (wr_ptr_q != rd_ptr_d);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= shift_q;
        end
    end

    always_ff @(posedge clk or negedge power_on_reset_n) begin
        if (!power_on_reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_data_q   <= 8'd0;
            rd_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= head_vld_d;
            if (head_vld_d) begin
                rd_data_q <= mem[rd_ptr_d[AW-1:0]];
            end
            // Set beats clear when both happen on one edge.
            frame_err_q <= frame_set | (frame_err_q & ~clear_err);
            overrun_q   <= ovr_set | (overrun_q & ~clear_err);
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Purpose : directed bench for uart_rx_fifo with a queue-based reference model.
// Latency : frames are driven at CPB clocks per bit; bench time stays 1ns after a rising edge.
// Backpressure: rd_ready is driven by the stimulus; every pop is checked against the model head.
module tb_uart_rx_fifo;

    localparam int CPB   = 32;
    localparam int DEPTH = 4;
    // Edge (counted from the edge before the start bit is driven) on which the
    // stop bit is sampled: 2 sync flops + 1 IDLE edge + (CPB-1)/2 + 9*CPB.
    localparam int STOP_EDGE = 3 + (CPB - 1) / 2 + 9 * CPB;

    logic       clk;
    logic       power_on_reset_n;
    logic       rxd;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic       frame_err;
    logic       overrun;
    logic       clear_err;
    logic       busy;

    uart_rx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFODEPTH    (DEPTH)
    ) dut (
        .clk              (clk),
        .power_on_reset_n (power_on_reset_n),
        .rxd              (rxd),
        .rd_data          (rd_data),
        .rd_valid         (rd_valid),
        .rd_ready         (rd_ready),
        .frame_err        (frame_err),
        .overrun          (overrun),
        .clear_err        (clear_err),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: bytes that must be in the FIFO, and the sticky flags.
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic       m_frm;
    logic       m_ovr;
    logic       quiet;
    int         n_checks;
    int         n_fail;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v);
        rxd = v;
        tick(CPB);
    endtask

    // One 8N1 frame; the model decides the byte's fate by the frame's rules.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        quiet = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
        if (!stop) m_frm = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else m_ovr = 1'b1;
    endtask

    task automatic settle();
        tick(4);
        quiet = 1'b1;
    endtask

    task automatic drain();
        int guard;
        guard    = 0;
        rd_ready = 1'b1;
        while (exp_q.size() != 0 && guard < 4 * DEPTH) begin
            tick(1);
            guard++;
        end
        rd_ready = 1'b0;
        chk("drain_done", 8'(exp_q.size()), 8'd0);
        tick(1);
    endtask

    task automatic clear_pulse();
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        m_frm     = 1'b0;
        m_ovr     = 1'b0;
    endtask

    // Expected read-out order packed LSB-first: byte i in bytes[8*i +: 8].
    task automatic check_got(input string name, input int n, input logic [63:0] bytes);
        chk({name, "_count"}, 8'(got_q.size()), 8'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got_q.size()) chk(name, got_q[i], bytes[8*i +: 8]);
        end
        got_q.delete();
    endtask

    // Compare process: state outputs whenever the line is settled, and every pop.
    always @(negedge clk) begin
        if (quiet && power_on_reset_n) begin
            chk("cmp_rd_valid", 8'(rd_valid), 8'(exp_q.size() != 0));
            if (exp_q.size() != 0) chk("cmp_rd_data", rd_data, exp_q[0]);
            chk("cmp_frame_err", 8'(frame_err), 8'(m_frm));
            chk("cmp_overrun", 8'(overrun), 8'(m_ovr));
            chk("cmp_busy", 8'(busy), 8'd0);
        end
        if (power_on_reset_n && rd_valid && rd_ready) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", rd_data, 8'hxx);
            end else begin
                chk("pop_data", rd_data, exp_q[0]);
                got_q.push_back(rd_data);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        m_frm            = 1'b0;
        m_ovr            = 1'b0;
        quiet            = 1'b0;
        rxd              = 1'b1;
        rd_ready         = 1'b0;
        clear_err        = 1'b0;
        power_on_reset_n = 1'b0;
        tick(3);

        // Reset state
        chk("rst_rd_valid", 8'(rd_valid), 8'd0);
        chk("rst_rd_data", rd_data, 8'h00);
        chk("rst_frame_err", 8'(frame_err), 8'd0);
        chk("rst_overrun", 8'(overrun), 8'd0);
        chk("rst_busy", 8'(busy), 8'd0);
        power_on_reset_n = 1'b1;
        tick(4);
        quiet = 1'b1;

        // Single byte with exact push latency
        fork
            send_frame(8'h55, 1'b1);
            begin
                tick(STOP_EDGE);
                chk("sb_valid_on_push_edge", 8'(rd_valid), 8'd0);
                tick(1);
                chk("sb_valid_next_edge", 8'(rd_valid), 8'd1);
                chk("sb_data", rd_data, 8'h55);
            end
        join
        settle();
        chk("sb_frame_err", 8'(frame_err), 8'd0);
        chk("sb_overrun", 8'(overrun), 8'd0);
        drain();
        check_got("sb_read", 1, 64'h55);

        // Back-to-back burst, no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        settle();
        drain();
        check_got("burst_read", 4, 64'h3C_A5_FF_00);
        chk("burst_empty", 8'(rd_valid), 8'd0);

        // Overrun: fifth byte dropped
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        settle();
        chk("ovr_flag", 8'(overrun), 8'd1);
        drain();
        check_got("ovr_read", 4, 64'h04_03_02_01);
        clear_pulse();
        chk("ovr_cleared", 8'(overrun), 8'd0);

        // Framing error followed by a 30-bit break, then a good byte
        send_frame(8'h81, 1'b0);
        tick(30 * CPB);
        chk("brk_busy", 8'(busy), 8'd1);
        chk("brk_no_byte", 8'(rd_valid), 8'd0);
        chk("brk_frame_err", 8'(frame_err), 8'd1);
        rxd = 1'b1;
        tick(CPB);
        settle();
        send_frame(8'h42, 1'b1);
        settle();
        drain();
        check_got("brk_read", 1, 64'h42);

        // Glitch shorter than half a bit
        quiet = 1'b0;
        rxd   = 1'b0;
        tick(CPB / 4);
        chk("glitch_busy", 8'(busy), 8'd1);
        rxd = 1'b1;
        tick(3 * CPB);
        settle();
        chk("glitch_idle", 8'(busy), 8'd0);
        chk("glitch_no_byte", 8'(rd_valid), 8'd0);

        // Full FIFO, pop on the exact stop-sample edge of a fifth byte
        for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1);
        settle();
        fork
            send_frame(8'h14, 1'b1);
            begin
                tick(STOP_EDGE - 1);
                rd_ready = 1'b1;
                tick(1);
                rd_ready = 1'b0;
            end
        join
        settle();
        chk("simul_no_overrun", 8'(overrun), 8'd0);
        drain();
        check_got("simul_read", 5, 64'h14_13_12_11_10);

        // Reset during data bit 3 of 0x99, with a byte queued and frame_err set
        send_frame(8'h5A, 1'b1);
        settle();
        quiet = 1'b0;
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b0);
        rxd = 1'b1;
        tick(CPB / 2);
        power_on_reset_n = 1'b0;
        exp_q.delete();
        m_frm = 1'b0;
        m_ovr = 1'b0;
        tick(2);
        chk("midrst_rd_valid", 8'(rd_valid), 8'd0);
        chk("midrst_rd_data", rd_data, 8'h00);
        chk("midrst_frame_err", 8'(frame_err), 8'd0);
        chk("midrst_busy", 8'(busy), 8'd0);
        power_on_reset_n = 1'b1;
        tick(2 * CPB);
        settle();
        send_frame(8'h66, 1'b1);
        settle();
        drain();
        check_got("midrst_read", 1, 64'h66);

        quiet = 1'b0;
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
